// File: rtl/ps2_keys_pkg.sv
// ============================================================================
// Module   : ps2_keys_pkg
// Brief    : Shared scan codes, key bit indices, decoder state encoding and
//            scan-code-to-key-mask helpers for the PS/2 arrow-key block.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_keys_pkg;

  // Scan codes (set 2)
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_A     = 8'h1C;

  // Bit positions inside the {U,D,R,L} key vector
  localparam int KEY_U = 3;
  localparam int KEY_D = 2;
  localparam int KEY_R = 1;
  localparam int KEY_L = 0;

  // Decoder states: where we are inside a make/break prefix sequence
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_EXT_BRK = 2'd2,
    ST_BRK     = 2'd3
  } dec_state_t;

  // One-hot key mask for an arrow scan code (after the E0 prefix), 0 otherwise
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m[KEY_U] = 1'b1;
      SC_DOWN:  m[KEY_D] = 1'b1;
      SC_RIGHT: m[KEY_R] = 1'b1;
      SC_LEFT:  m[KEY_L] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  // One-hot key mask for a non-extended W/S/D/A scan code, 0 otherwise
  function automatic logic [3:0] wasd_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_W:    m[KEY_U] = 1'b1;
      SC_S:    m[KEY_D] = 1'b1;
      SC_D:    m[KEY_R] = 1'b1;
      SC_A:    m[KEY_L] = 1'b1;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module   : ps2_rx
// Brief    : PS/2 device-to-host receiver. Synchronises the raw pins, filters
//            ps2_clk falling edges, shifts in 11-bit frames and flags parity,
//            stop-bit and mid-frame timeout errors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_rx #(
  parameter int PS2_TIMEOUT = 65000
) (
  input  logic       clk,
  input  logic       rst,        // asynchronous, active-low
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int C_TO_W = $clog2(PS2_TIMEOUT + 1);
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(PS2_TIMEOUT - 1);

  logic [1:0]        r_clk_sync;
  logic [1:0]        r_dat_sync;
  logic [2:0]        r_clk_hist;
  logic [3:0]        r_bit_cnt;
  logic [8:0]        r_shift;
  logic [C_TO_W-1:0] r_to_cnt;
  logic [7:0]        r_byte;
  logic              r_valid;
  logic              r_err;
  logic              w_fall;
  logic              w_bit;

  // Two-flop synchronisers plus a short history of the synchronised clock.
  // Idle PS/2 lines are high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_hist <= 3'b111;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_clk_hist <= {r_clk_hist[1:0], r_clk_sync[1]};
    end
  end

  // A qualified falling edge: was high, then low for two consecutive samples
  assign w_fall = (r_clk_hist == 3'b100);
  assign w_bit  = r_dat_sync[1];

  // Frame receiver with timeout; bit count 1..9 shifts data+parity, 10 is stop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 9'd0;
      r_to_cnt  <= '0;
      r_byte    <= 8'd0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd0) begin
          // A high start bit is line noise: stay idle, no error
          if (!w_bit) begin
            r_bit_cnt <= 4'd1;
          end
        end else if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= 4'd0;
          // Odd parity over data+parity, and stop must be 1
          if ((^r_shift) && w_bit) begin
            r_byte  <= r_shift[7:0];
            r_valid <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end else begin
          r_shift   <= {w_bit, r_shift[8:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_to_cnt == C_TO_LAST) begin
          r_bit_cnt <= 4'd0;
          r_to_cnt  <= '0;
          r_err     <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign rx_byte    = r_byte;
  assign byte_valid = r_valid;
  assign err        = r_err;

endmodule

`default_nettype wire

// File: rtl/ps2_arrow_keys.sv
// ============================================================================
// Module   : ps2_arrow_keys
// Brief    : Decodes PS/2 arrow make/break codes into a held-key vector and
//            emits rate-limited one-cycle step pulses {U,D,R,L}.
//            Optional macro KEYS_WASD_EN: W/S/D/A also drive the held bits.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_arrow_keys
  import ps2_keys_pkg::*;
#(
  parameter int STEP_DIV    = 650000,
  parameter int PS2_TIMEOUT = 65000
) (
  input  logic       clk,
  input  logic       rst,        // asynchronous, active-low
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keys,
  output logic [3:0] keys_held,
  output logic       frame_err
);

  localparam int C_CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(STEP_DIV - 1);

  logic [7:0]         w_byte;
  logic               w_byte_valid;
  logic               w_rx_err;
  dec_state_t         r_state;
  logic [3:0]         r_held;
  logic [C_CNT_W-1:0] r_cnt;
  logic [3:0]         r_keys;

  ps2_rx #(
    .PS2_TIMEOUT (PS2_TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (w_byte),
    .byte_valid (w_byte_valid),
    .err        (w_rx_err)
  );

  // Prefix decoder and held-key register, advanced once per received byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_held  <= 4'b0000;
    end else if (w_byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte == SC_EXT) begin
            r_state <= ST_EXT;
          end else if (w_byte == SC_BRK) begin
            r_state <= ST_BRK;
          end else begin
            r_state <= ST_IDLE;
`ifdef KEYS_WASD_EN
            r_held <= r_held | wasd_mask(w_byte);
`endif
          end
        end
        ST_EXT: begin
          if (w_byte == SC_BRK) begin
            r_state <= ST_EXT_BRK;
          end else begin
            // Typematic repeats simply re-set an already set bit
            r_held  <= r_held | arrow_mask(w_byte);
            r_state <= ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          r_held  <= r_held & ~arrow_mask(w_byte);
          r_state <= ST_IDLE;
        end
        ST_BRK: begin
`ifdef KEYS_WASD_EN
          r_held <= r_held & ~wasd_mask(w_byte);
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Step generator: pulse on cnt==0 while any key is held, using the
  // held value of this cycle even if a byte updates it at the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_keys <= 4'b0000;
    end else begin
      if (r_held == 4'b0000) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_keys <= ((r_cnt == '0) && (r_held != 4'b0000)) ? r_held : 4'b0000;
    end
  end

  assign keys      = r_keys;
  assign keys_held = r_held;
  assign frame_err = w_rx_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_arrow_keys.sv
// ============================================================================
// Module   : tb_ps2_arrow_keys
// Brief    : Scoreboard bench for ps2_arrow_keys. Stimulus works at the level
//            of key presses/releases; a monitor compares held changes, error
//            pulses and step pulses against expectations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_arrow_keys;

  localparam int STEP_DIV    = 4;
  localparam int PS2_TIMEOUT = 200;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] keys;
  logic [3:0] keys_held;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

  logic [3:0] model_held = 4'b0000;
  logic [3:0] held_q[$];
  int         err_q[$];

  // Arrow codes indexed by key bit (L,R,D,U)
  logic [7:0] arrow_code [4] = '{8'h6B, 8'h74, 8'h72, 8'h75};

  ps2_arrow_keys #(
    .STEP_DIV    (STEP_DIV),
    .PS2_TIMEOUT (PS2_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keys      (keys),
    .keys_held (keys_held),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: held changes pop held_q, error pulses pop err_q, step pulses
  // must follow the held value with period STEP_DIV from the first held cycle
  logic [3:0] mon_prev_held = 4'b0000;
  int         mon_run       = 0;
  always @(negedge clk) begin
    logic [3:0] exp_keys;
    if (!rst) begin
      mon_prev_held = 4'b0000;
      mon_run       = 0;
    end else begin
      exp_keys = ((mon_prev_held != 4'b0000) && (((mon_run - 1) % STEP_DIV) == 0))
                 ? mon_prev_held : 4'b0000;
      check4("keys_pulse", keys, exp_keys);
      if (keys_held !== mon_prev_held) begin
        if (held_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL held_unexpected: got %b expected %b at %0t", keys_held, mon_prev_held, $time);
        end else begin
          check4("held_change", keys_held, held_q.pop_front());
        end
      end
      if (frame_err === 1'b1) begin
        checks++;
        if (err_q.size() == 0) begin
          failures++;
          $display("FAIL frame_err_unexpected: got 1 expected 0 at %0t", $time);
        end else begin
          void'(err_q.pop_front());
        end
      end
      mon_run       = (keys_held != 4'b0000) ? mon_run + 1 : 0;
      mon_prev_held = keys_held;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic b, input int half);
    ps2_data = b;
    wait_clks(half);
    ps2_clk = 1'b0;
    wait_clks(half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int half;
    half = $urandom_range(5, 10);
    ps2_bit(1'b0, half);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
    ps2_bit((~^b) ^ bad_par, half);
    ps2_bit(!bad_stop, half);
    ps2_data = 1'b1;
    wait_clks($urandom_range(12, 30));
  endtask

  // Start bit plus (nbits-1) data bits, then the line simply stops
  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 6);
    for (int i = 0; i < nbits - 1; i++) ps2_bit(b[i], 6);
    ps2_data = 1'b1;
  endtask

  task automatic key_make(input int k);
    send_frame(8'hE0, 0, 0);
    if (!model_held[k]) begin
      model_held[k] = 1'b1;
      held_q.push_back(model_held);
    end
    send_frame(arrow_code[k], 0, 0);
  endtask

  task automatic key_break(input int k);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    if (model_held[k]) begin
      model_held[k] = 1'b0;
      held_q.push_back(model_held);
    end
    send_frame(arrow_code[k], 0, 0);
  endtask

  // Wait (bounded) for outstanding expectations, then compare the held state
  task automatic check_held(input string name);
    int n;
    n = 0;
    while ((held_q.size() != 0 || err_q.size() != 0) && n < 100) begin
      wait_clks(1);
      n++;
    end
    checks++;
    if (held_q.size() != 0 || err_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d held/%0d err outstanding expected 0/0",
               name, held_q.size(), err_q.size());
      held_q.delete();
      err_q.delete();
    end
    @(negedge clk);
    check4(name, keys_held, model_held);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         op;
    int         k;
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(3);
    #1;
    check4("reset_keys", keys, 4'b0000);
    check4("reset_held", keys_held, 4'b0000);
    check4("reset_err", {3'b000, frame_err}, 4'b0000);
    rst = 1'b1;
    wait_clks(5);

    // Up press and release
    key_make(3);
    check_held("up_make");
    wait_clks(25);
    key_break(3);
    check_held("up_break");
    wait_clks(20);

    // Right + Left together, then release Right
    key_make(1);
    key_make(0);
    check_held("rl_make");
    wait_clks(20);
    key_break(1);
    check_held("r_break");
    key_break(0);
    check_held("l_break");

    // Bad-parity E0 discarded; the following 75 arrives in IDLE and is ignored
    err_q.push_back(1);
    send_frame(8'hE0, 1, 0);
    send_frame(8'h75, 0, 0);
    check_held("bad_parity");

    // Bad stop bit
    err_q.push_back(1);
    send_frame(8'h72, 0, 1);
    check_held("bad_stop");

    // Partial frame then stall past the timeout
    err_q.push_back(1);
    send_partial(8'hE0, 6);
    wait_clks(250);
    key_make(2);
    check_held("after_timeout");

    // Asynchronous reset mid-frame while Down is held
    wait_clks(7);
    send_partial(8'hE0, 4);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check4("async_rst_keys", keys, 4'b0000);
    check4("async_rst_held", keys_held, 4'b0000);
    check4("async_rst_err", {3'b000, frame_err}, 4'b0000);
    model_held = 4'b0000;
    held_q.delete();
    err_q.delete();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(5);
    rst = 1'b1;
    wait_clks(5);
    key_make(0);
    check_held("after_reset");
    key_break(0);
    check_held("after_reset_break");

    // W make / break: only effective with the optional WASD decoding
`ifdef KEYS_WASD_EN
    model_held[3] = 1'b1;
    held_q.push_back(model_held);
`endif
    send_frame(8'h1D, 0, 0);
    check_held("w_make");
    send_frame(8'hF0, 0, 0);
`ifdef KEYS_WASD_EN
    model_held[3] = 1'b0;
    held_q.push_back(model_held);
`endif
    send_frame(8'h1D, 0, 0);
    check_held("w_break");

    // Randomised key activity, noise bytes, typematic repeats and bad frames
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      k  = $urandom_range(0, 3);
      if (op <= 3 || op == 9) begin
        key_make(k);
        if (op == 9) key_make(k);
      end else if (op <= 6) begin
        key_break(k);
      end else if (op == 7) begin
        do b = 8'($urandom_range(0, 255));
        while (b == 8'hE0 || b == 8'hF0 || b == 8'h1D || b == 8'h1B ||
               b == 8'h23 || b == 8'h1C);
        send_frame(b, 0, 0);
      end else begin
        err_q.push_back(1);
        send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, 1'b1);
      end
      wait_clks($urandom_range(0, 15));
      if (it % 5 == 4) check_held("random");
    end
    for (int j = 0; j < 4; j++) key_break(j);
    check_held("final_release");
    wait_clks(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_arrow_keys.md
Name: ps2_arrow_keys

Overview:
- Produces the 4-bit movement key vector {keyU,keyD,keyR,keyL} that the player-position controller consumes.
- Receives PS/2 keyboard frames, decodes arrow-key make/break scan codes and tracks which arrows are held.
- Emits rate-limited one-cycle step pulses, so one pulse equals one pixel of movement downstream.
- Sits between the board PS/2 pins and the position controller, in the VGA pixel-clock domain.

Parameters:
- STEP_DIV, 650000, clock cycles between step pulses while any arrow is held (100 Hz at 65 MHz).
- PS2_TIMEOUT, 65000, idle cycles mid-frame after which a partial frame is discarded.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- keys  out  4  step pulse vector {U,D,R,L}, high for one cycle per step
- keys_held  out  4  level vector {U,D,R,L}, current held state
- frame_err  out  1  one-cycle pulse on a bad parity or stop bit, or on a timeout

Behaviour:
- Reset: one clock; rst is asynchronous and active-low. While rst=0, keys=0, keys_held=0, frame_err=0, and the step counter, bit counter, shift register and decoder FSM are all cleared to IDLE. Reset asserted mid-frame or mid-sequence discards all partial state.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchroniser. A falling edge on ps2_clk is a synchronised 1->0 transition held for 2 consecutive samples.
- Frame: 11 bits sampled on falling edges: start=0, 8 data bits LSB first, odd parity, stop=1.
- Frame acceptance:
  - Start bit must be 0, otherwise the receiver stays idle and no error is flagged.
  - After the stop bit, the byte is valid only if parity is odd and stop=1.
  - A valid byte produces a one-cycle byte_valid strobe.
  - A bad parity or stop bit discards the byte and pulses frame_err; the decoder state is unchanged.
- Timeout: PS2_TIMEOUT cycles with no falling edge while bit count is nonzero: bit count returns to 0 and frame_err pulses.
- Decoder FSM, advanced only on byte_valid:
  - IDLE: E0->EXT; F0->BRK; any other byte->IDLE.
  - EXT: F0->EXT_BRK. 75/72/74/6B set held U/D/R/L respectively, then ->IDLE. Any other byte->IDLE.
  - EXT_BRK: 75/72/74/6B clear the matching held bit, then ->IDLE. Any other byte->IDLE.
  - BRK: any byte->IDLE. No held change unless KEYS_WASD_EN is defined.
- Held state:
  - Typematic repeats (repeated make codes) leave the held bit set, with no extra effect.
  - Several bits may be set at once; no priority is applied here, because the consumer resolves priority U>D>R>L.
- Step generator:
  - cnt counts 0..STEP_DIV-1 and wraps while keys_held!=0.
  - cnt is forced to 0 while keys_held==0.
  - keys <= (cnt==0 && keys_held!=0) ? keys_held : 0, registered.
  - First pulse arrives 1 cycle after keys_held becomes nonzero; subsequent pulses every STEP_DIV cycles.
  - Releasing all arrows stops pulses immediately. A pulse already registered still completes its single cycle.
- Widths: cnt is clog2(STEP_DIV) bits; the timeout counter is clog2(PS2_TIMEOUT+1) bits; the bit counter is 4 bits.
- Simultaneous byte_valid and step tick: the held update applies from the next cycle; the tick uses the current keys_held.

Optional Feature:
- Macro: KEYS_WASD_EN.
- Defined:
  - Non-extended make codes 1D/1B/23/1C (W/S/D/A) in IDLE set U/D/R/L.
  - The same codes in BRK clear the matching bit.
  - Arrow and WASD keys share held bits; releasing either key clears the bit.
- Undefined: only the E0-prefixed arrow codes affect held state.

Decomposition:
- Shared package/header ps2_keys_pkg holds:
  - scan code constants: SC_EXT=E0, SC_BRK=F0, SC_UP=75, SC_DOWN=72, SC_RIGHT=74, SC_LEFT=6B, SC_W=1D, SC_S=1B, SC_D=23, SC_A=1C;
  - key bit indices: KEY_U=3, KEY_D=2, KEY_R=1, KEY_L=0;
  - FSM state encodings.
- One sub-module, ps2_rx: synchroniser, edge filter, 11-bit frame receiver and timeout. Outputs byte[7:0], byte_valid and err.
- The top level keeps the decoder FSM, held register and step generator.

Test Plan (STEP_DIV=4, PS2_TIMEOUT=200, 10-cycle-or-slower PS/2 bit period):
- Send E0,75 -> keys_held=1000; keys=1000 for one cycle, then again exactly every 4 cycles. Send E0,F0,75 -> keys_held=0000, no further pulses.
- Send E0,74 then E0,6B -> keys_held=0011; pulses carry 0011. Send E0,F0,74 -> keys_held=0001.
- Send E0 with parity bit flipped, then 75 -> one frame_err pulse; FSM in IDLE so 75 is ignored; keys_held=0000.
- Send 6 bits of a frame, then stall 250 cycles -> frame_err pulses once. Then send E0,72 -> keys_held=0100.
- Hold E0,72, then drive rst=0 asynchronously between clock edges mid-frame -> keys, keys_held and frame_err all 0 immediately. After release, E0,6B -> keys_held=0001.
- With KEYS_WASD_EN: send 1D -> keys_held=1000; send F0,1D -> 0000. Without the macro: 1D -> keys_held stays 0000.
